vector_detector_stream: RTL and testbench
=========================================

VECTOR_DETECTOR_STREAM -- requirements
Module: vector_detector_stream

Interface
REQ-001 Parameter DATA_W, default 32, width of one input word in bits; power of 2, at least 4.
REQ-002 Parameter MAX_WORDS, default 4, maximum words per frame; power of 2, at least 2.
REQ-003 Derived constants: POS_W = clog2(MAX_WORDS*DATA_W); CNT_W = clog2(MAX_WORDS)+1.
REQ-004 One clock; reset is asynchronous and active-low. Ports are named clk and rst as in the existing blocks; rst is active-low here.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 mode_msb  input  1  scan direction: 1 = MSB-first within each word, 0 = LSB-first; sampled on the first accepted word of a frame.
REQ-008 in_valid  input  1  in_data, in_last and mode_msb are valid.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 in_data  input  DATA_W  vector word.
REQ-011 in_last  input  1  final word of the frame.
REQ-012 out_valid  output  1  frame result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_found  output  1  at least one set bit in the frame.
REQ-015 out_pos  output  POS_W  global position of the first set bit.
REQ-016 out_words  output  CNT_W  number of words consumed by the frame.
REQ-017 out_trunc  output  1  frame was closed at MAX_WORDS without in_last.

Function
REQ-018 A transfer occurs on any rising edge where in_valid and in_ready are both 1; the same rule applies to out_valid and out_ready.
REQ-019 The state machine has three states: IDLE (no frame open), SCAN (frame open), HOLD (result presented).
REQ-020 in_ready is 1 in IDLE and SCAN and 0 in HOLD; out_valid is 1 only in HOLD.
REQ-021 Per-word detection: MSB mode returns the highest set bit index; LSB mode returns the lowest set bit index; an all-zero word is a miss.
REQ-022 Words are scanned in arrival order, word index k starting at 0; the first word that hits fixes out_pos = k*DATA_W + bit index and sets out_found.
REQ-023 Words after the first hit are consumed and counted but do not change out_pos or out_found.
REQ-024 The direction latched at the first word applies to the whole frame; mode_msb changes mid-frame are ignored.
REQ-025 Transitions: IDLE -> SCAN on accepting a word with in_last=0; IDLE -> HOLD on accepting a word with in_last=1 (single-word frame).
REQ-026 SCAN -> HOLD on accepting a word with in_last=1, or on accepting word number MAX_WORDS; in the latter case out_trunc=1.
REQ-027 HOLD -> IDLE on an output transfer; in_ready returns to 1 in the following cycle, with no same-cycle bypass.
REQ-028 Latency: out_valid rises on the cycle after the rising edge that accepts the closing word.
REQ-029 out_found, out_pos, out_words and out_trunc are registered and stay stable throughout HOLD.
REQ-030 Frame with no set bit: out_found=0 and out_pos=0.
REQ-031 out_words counts every accepted word in the frame, range 1..MAX_WORDS.
REQ-032 The next frame starts from cleared accumulators; no result carries over between frames.
REQ-033 If in_last=1 arrives on word MAX_WORDS, the frame closes normally with out_trunc=0.

Reset
REQ-034 While rst=0: state = IDLE, in_ready=1, out_valid=0, out_found=0, out_pos=0, out_words=0, out_trunc=0, word counter=0, latched mode=0.
REQ-035 An assertion of rst mid-frame or during HOLD discards the partial frame or pending result immediately; no out_valid follows.
REQ-036 Deassertion of rst is synchronised so the first transfer can occur no earlier than the second rising edge after release.

Verification
REQ-037 Single word, DATA_W=32, mode_msb=1, in_data=0x0001_8000, in_last=1 -> next cycle out_valid=1, out_found=1, out_pos=16, out_words=1, out_trunc=0.
REQ-038 Same word with mode_msb=0 -> out_pos=15.
REQ-039 Three-word frame 0x0, 0x0000_0004, 0x8000_0000 (last), mode_msb=0 -> out_pos=34, out_found=1, out_words=3.
REQ-040 Four all-zero words, none with in_last, MAX_WORDS=4 -> out_found=0, out_pos=0, out_words=4, out_trunc=1; a fifth word is held off (in_ready=0) until the result is taken.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0 throughout; out_ready=1 -> out_valid falls and in_ready=1 on the next cycle.
REQ-042 Drive rst=0 after word 2 of a 3-word frame -> all outputs return to their reset values immediately; a new single-word frame 0x1 (mode_msb=1) -> out_pos=0, out_found=1.

Source files
------------

// File: rtl/vector_detector_stream_if.sv
// Stream bundle for the first-set-bit vector detector: word input side
// and frame-result output side, each with a valid/ready handshake.
interface vector_detector_stream_if #(
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 4
);
   localparam int POS_W = $clog2(MAX_WORDS * DATA_W);
   localparam int CNT_W = $clog2(MAX_WORDS) + 1;

   logic              mode_msb;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic              out_found;
   logic [POS_W-1:0]  out_pos;
   logic [CNT_W-1:0]  out_words;
   logic              out_trunc;

   modport master (
      output mode_msb, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_found, out_pos, out_words, out_trunc
   );

   modport slave (
      input  mode_msb, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_found, out_pos, out_words, out_trunc
   );
endinterface

// File: rtl/vector_detector_stream.sv
// Finds the first set bit of a multi-word frame (MSB- or LSB-first per word)
// and reports its global position, word count and truncation flag.
//
// state | meaning
// IDLE  | no frame open, waiting for the first word
// SCAN  | frame open, accumulating words
// HOLD  | result presented, input held off until taken
module vector_detector_stream #(
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 4
) (
   input logic                     clk,
   input logic                     rst,
   vector_detector_stream_if.slave bus
);
   localparam int POS_W = $clog2(MAX_WORDS * DATA_W);
   localparam int CNT_W = $clog2(MAX_WORDS) + 1;
   localparam int IDX_W = $clog2(MAX_WORDS);
   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic [BIT_W-1:0] msb_idx(input logic [DATA_W-1:0] d);
      logic [BIT_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++)
         if (d[i]) r = BIT_W'(i);
      return r;
   endfunction

   function automatic logic [BIT_W-1:0] lsb_idx(input logic [DATA_W-1:0] d);
      logic [BIT_W-1:0] r;
      r = '0;
      for (int i = DATA_W - 1; i >= 0; i--)
         if (d[i]) r = BIT_W'(i);
      return r;
   endfunction

   state_t           state;
   logic [1:0]       rst_sync;
   logic             rst_int;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             mode_q;
   logic             found_q;
   logic             trunc_q;
   logic [POS_W-1:0] pos_q;
   logic [CNT_W-1:0] word_cnt;

   logic             accept;
   logic             mode_eff;
   logic             found_prev;
   logic             hit;
   logic             at_max;
   logic [IDX_W-1:0] k_idx;
   logic [CNT_W-1:0] cnt_next;
   logic [BIT_W-1:0] bit_idx;

   // Reset asserts immediately, releases only after two clean clock edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int = rst_sync[1];

   assign accept     = bus.in_valid && in_ready_q;
   assign mode_eff   = (state == IDLE) ? bus.mode_msb : mode_q;
   assign k_idx      = (state == IDLE) ? '0 : word_cnt[IDX_W-1:0];
   assign cnt_next   = (state == IDLE) ? CNT_W'(1) : word_cnt + CNT_W'(1);
   assign found_prev = (state != IDLE) && found_q;
   assign hit        = |bus.in_data;
   assign bit_idx    = mode_eff ? msb_idx(bus.in_data) : lsb_idx(bus.in_data);
   assign at_max     = (cnt_next == CNT_W'(MAX_WORDS));

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mode_q      <= 1'b0;
         found_q     <= 1'b0;
         trunc_q     <= 1'b0;
         pos_q       <= '0;
         word_cnt    <= '0;
      end else begin
         case (state)
            IDLE, SCAN: begin
               if (accept) begin
                  mode_q   <= mode_eff;
                  word_cnt <= cnt_next;
                  trunc_q  <= !bus.in_last && at_max;
                  // Only the first hitting word fixes the position; a new frame clears it.
                  if (!found_prev && hit) begin
                     found_q <= 1'b1;
                     pos_q   <= {k_idx, bit_idx};
                  end else if (state == IDLE) begin
                     found_q <= 1'b0;
                     pos_q   <= '0;
                  end
                  if (bus.in_last || at_max) begin
                     state       <= HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_found = found_q;
   assign bus.out_pos   = pos_q;
   assign bus.out_words = word_cnt;
   assign bus.out_trunc = trunc_q;
endmodule

// File: tb/tb_vector_detector_stream.sv
// Bench for vector_detector_stream: directed frames plus randomized frames
// checked against a loop-based first-set-bit model.
module tb_vector_detector_stream;
   localparam int DATA_W    = 32;
   localparam int MAX_WORDS = 4;

   logic clk;
   logic rst;
   int   vectors;
   int   errs;

   vector_detector_stream_if #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) bus ();

   vector_detector_stream #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_word(input logic [31:0] d, input logic l, input logic m);
      int n;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.mode_msb = m;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         vectors++; errs++;
         $display("FAIL push_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic pop_result(input string name, input logic ef, input logic [6:0] ep,
                             input logic [2:0] ew, input logic et);
      int n;
      logic [11:0] got, exp;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (n >= 50) begin
         errs++;
         $display("FAIL %s_timeout: out_valid stayed %b, required 1", name, bus.out_valid);
      end
      got = {bus.out_found, bus.out_pos, bus.out_words, bus.out_trunc};
      exp = {ef, ep, ew, et};
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: found/pos/words/trunc got %b/%0d/%0d/%b required %b/%0d/%0d/%b",
                  name, got[11], got[10:4], got[3:1], got[0], ef, ep, ew, et);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errs++;
         $display("FAIL %s_release: out_valid/in_ready got %b/%b required 0/1",
                  name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic release_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.out_found, bus.out_pos, bus.out_words, bus.out_trunc}
          !== {1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0}) begin
         errs++;
         $display("FAIL %s: rdy/vld/found/pos/words/trunc got %b/%b/%b/%0d/%0d/%b required 1/0/0/0/0/0",
                  name, bus.in_ready, bus.out_valid, bus.out_found, bus.out_pos,
                  bus.out_words, bus.out_trunc);
      end
   endtask

   task automatic check_latency(input string name);
      vectors++;
      if (bus.out_valid !== 1'b1) begin
         errs++;
         $display("FAIL %s_latency: out_valid got %b required 1", name, bus.out_valid);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      release_reset();
      check_reset_outputs("after_release");
   endtask

   task automatic test_single_word();
      push_word(32'h0001_8000, 1'b1, 1'b1);
      check_latency("single_msb");
      pop_result("single_msb", 1'b1, 7'd16, 3'd1, 1'b0);
      push_word(32'h0001_8000, 1'b1, 1'b0);
      check_latency("single_lsb");
      pop_result("single_lsb", 1'b1, 7'd15, 3'd1, 1'b0);
   endtask

   task automatic test_multi_word();
      push_word(32'h0000_0000, 1'b0, 1'b0);
      push_word(32'h0000_0004, 1'b0, 1'b0);
      push_word(32'h8000_0000, 1'b1, 1'b0);
      check_latency("three_word");
      pop_result("three_word", 1'b1, 7'd34, 3'd3, 1'b0);
      // mode flips on word 2 must be ignored
      push_word(32'h0000_0000, 1'b0, 1'b0);
      push_word(32'h0000_0101, 1'b1, 1'b1);
      pop_result("mode_latched", 1'b1, 7'd32, 3'd2, 1'b0);
      push_word(32'h0000_0000, 1'b0, 1'b1);
      push_word(32'h0000_0000, 1'b0, 1'b1);
      push_word(32'h0000_0000, 1'b0, 1'b1);
      push_word(32'h0000_0010, 1'b1, 1'b1);
      pop_result("last_at_max", 1'b1, 7'd100, 3'd4, 1'b0);
   endtask

   task automatic test_trunc_backpressure();
      repeat (4) push_word(32'h0, 1'b0, 1'b1);
      check_latency("trunc");
      bus.in_data  = 32'h0;
      bus.in_last  = 1'b1;
      bus.mode_msb = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if ({bus.in_ready, bus.out_valid, bus.out_found, bus.out_pos, bus.out_words, bus.out_trunc}
             !== {1'b0, 1'b1, 1'b0, 7'd0, 3'd4, 1'b1}) begin
            errs++;
            $display("FAIL hold_stable cycle %0d: rdy/vld/found/pos/words/trunc got %b/%b/%b/%0d/%0d/%b required 0/1/0/0/4/1",
                     c, bus.in_ready, bus.out_valid, bus.out_found, bus.out_pos,
                     bus.out_words, bus.out_trunc);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errs++;
         $display("FAIL hold_release: out_valid/in_ready got %b/%b required 0/1",
                  bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_latency("fifth_word");
      pop_result("fifth_word", 1'b0, 7'd0, 3'd1, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      push_word(32'h0000_0100, 1'b0, 1'b1);
      push_word(32'h0000_0000, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      check_reset_outputs("reset_mid_frame");
      repeat (2) @(posedge clk);
      #1;
      release_reset();
      push_word(32'h0000_0001, 1'b1, 1'b1);
      pop_result("after_reset", 1'b1, 7'd0, 3'd1, 1'b0);
      push_word(32'hF000_0000, 1'b1, 1'b1);
      check_latency("reset_in_hold");
      rst = 1'b0;
      #1;
      check_reset_outputs("reset_in_hold");
      @(posedge clk); #1;
      release_reset();
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         errs++;
         $display("FAIL no_stale_result: out_valid got %b required 0", bus.out_valid);
      end
   endtask

   task automatic test_random_frames();
      logic [31:0] w[4];
      logic        m[4];
      int          n, eb, epos;
      logic        lastf, ef;
      for (int f = 0; f < 60; f++) begin
         n = $urandom_range(1, MAX_WORDS);
         lastf = (n < MAX_WORDS) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
               0, 1:    w[k] = 32'h0;
               2:       w[k] = 32'h1 << $urandom_range(0, 31);
               default: w[k] = $urandom;
            endcase
            m[k] = 1'($urandom_range(0, 1));
         end
         ef = 1'b0;
         epos = 0;
         for (int k = 0; k < n; k++) begin
            if (!ef && w[k] != 32'h0) begin
               ef = 1'b1;
               eb = 0;
               if (m[0]) begin
                  for (int b = 0; b < 32; b++) if (w[k][b]) eb = b;
               end else begin
                  for (int b = 31; b >= 0; b--) if (w[k][b]) eb = b;
               end
               epos = k * DATA_W + eb;
            end
         end
         for (int k = 0; k < n; k++) begin
            push_word(w[k], (k == n - 1) ? lastf : 1'b0, m[k]);
            if (k < n - 1) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
         end
         check_latency("random");
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         pop_result("random", ef, 7'(epos), 3'(n), (n == MAX_WORDS) && !lastf);
      end
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.mode_msb  = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single_word();
      test_multi_word();
      test_trunc_backpressure();
      test_reset_mid_frame();
      test_random_frames();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
